vec_table_loader: RTL and testbench
===================================

Name: vec_table_loader

Overview:
- Boot-time loader that receives the 20-entry exception vector table as a byte stream and holds it in registers.
- Source is the boot serial/flash bridge.
- Drives the sp_addr/reset_addr/nmi_addr/fault_addr/irq0..15_addr inputs of the downstream AHB vector-table slave.
- Holds the CPU in reset until a complete table with a valid checksum has been committed.

Parameters:
- HDR_BYTE, 8'hA5, required first byte of a frame.
- TIMEOUT_CYC, 1024, maximum idle cycles between accepted bytes while a frame is open.

Ports:
- hclk  input  1  clock
- hreset  input  1  reset: synchronous, active-high. Single clock domain.
- start  input  1  one-cycle pulse that opens a load frame
- s_valid  input  1  stream byte valid
- s_data  input  8  stream byte
- s_ready  output  1  loader accepts s_data this cycle
- vec_valid  output  1  table committed and checksum good
- cpu_rst_hold  output  1  hold CPU in reset
- load_err  output  1  frame aborted
- err_code  output  2  0 none, 1 bad header, 2 bad checksum, 3 timeout
- sp_addr, reset_addr, nmi_addr, fault_addr  output  32 each  vector words 0-3
- irq0_addr .. irq15_addr  output  32 each  vector words 4-19

Behaviour:
- Reset values:
  - state IDLE; all vector registers 0.
  - vec_valid 0, cpu_rst_hold 1, load_err 0, err_code 0, s_ready 0.
  - Byte, word and timeout counters 0; checksum accumulator 0.
- Handshake: a byte is accepted on a cycle with s_valid & s_ready. s_ready is combinational on state: 1 in HDR, LOAD, CSUM; 0 otherwise.
- Frame format: HDR_BYTE, then 80 payload bytes (20 words, little-endian, word order sp, reset, nmi, fault, irq0..irq15), then 1 checksum byte.
- Checksum rule: sum of all 80 payload bytes plus the checksum byte, mod 256, must equal 8'h00.
- States and transitions:
  - IDLE: start -> HDR.
  - HDR: accepted byte == HDR_BYTE -> LOAD. Any other byte -> ERR with code 1.
  - LOAD: each accepted byte is shifted into byte lane byte_cnt of word word_cnt, and added to the accumulator.
    - byte_cnt wraps 3 -> 0 and increments word_cnt.
    - The 80th byte (word_cnt 19, byte_cnt 3) -> CSUM.
  - CSUM: accepted byte plus accumulator == 0 -> DONE. Otherwise -> ERR with code 2.
  - DONE: vec_valid 1, cpu_rst_hold 0. start -> HDR.
  - ERR: load_err 1, err_code held, cpu_rst_hold 1, vec_valid 0. start -> HDR.
- Entering HDR from any state:
  - clears vec_valid, load_err, err_code, counters and accumulator, and sets cpu_rst_hold 1;
  - clears the vector registers to 0 in the same cycle.
- Registered outputs:
  - vec_valid, cpu_rst_hold and load_err update on the clock edge at which the state changes.
  - vec_valid rises in the cycle after the checksum byte is accepted.
- Output masking: vector outputs are driven from the registers ANDed with vec_valid. Downstream therefore sees 0 until DONE, and never sees a partial table.
- Timeout: in HDR, LOAD and CSUM the counter increments every cycle without an accepted byte and clears on an accepted byte. When it reaches TIMEOUT_CYC-1 without a byte -> ERR with code 3.
- start while in HDR, LOAD or CSUM is ignored; the frame continues.
- An accepted byte and the timeout terminal count in the same cycle: the byte wins and the counter clears.
- s_valid while s_ready=0 has no effect. Bytes are never consumed outside a frame.
- hreset asserted mid-frame returns to the reset values on the next edge; the partial table is discarded.

Decomposition:
- Package vec_loader_pkg holds:
  - state encoding (IDLE, HDR, LOAD, CSUM, DONE, ERR);
  - err_code constants ERR_NONE/ERR_HDR/ERR_CSUM/ERR_TMO;
  - NUM_VEC=20, PAYLOAD_BYTES=80;
  - vector index constants VEC_SP=0, VEC_RESET=1, VEC_NMI=2, VEC_FAULT=3, VEC_IRQ0=4.
- One natural sub-module: vec_byte_assembler, containing the byte/word counters, lane write-enable decode and checksum accumulator.
- The FSM, timeout counter and output masking stay in the top level.

Test Plan:
- Nominal frame: start, A5, then words sp=32'h2000_1000, reset=32'h0000_0101, irq15=32'h0000_0F01 (others 0), correct checksum -> vec_valid=1 and cpu_rst_hold=0 one cycle after the checksum byte; sp_addr=32'h2000_1000, irq15_addr=32'h0000_0F01.
- Bad header: start, byte 8'h5A -> load_err=1, err_code=1, s_ready=0 next cycle, all vector outputs 0, cpu_rst_hold=1.
- Bad checksum: nominal frame with checksum+1 -> err_code=2, vec_valid=0, sp_addr reads 0.
- Timeout: start, A5, 10 bytes, then s_valid low for TIMEOUT_CYC cycles -> err_code=3 exactly TIMEOUT_CYC-1 cycles after the last accepted byte.
- Backpressure and abort:
  - random s_valid gaps shorter than TIMEOUT_CYC -> table still loads correctly;
  - start pulse mid-LOAD is ignored;
  - hreset at byte 40 -> all outputs return to reset values, and a following full frame loads cleanly.
- Reload: after DONE, start a second frame with nmi=32'hDEAD_BEEF -> vec_valid drops the cycle after start, outputs read 0 during the load, then nmi_addr=32'hDEAD_BEEF after commit.

Source files
------------

// File: rtl/vec_loader_pkg.sv
// Shared types and constants for the boot-time exception vector table loader.
package vec_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    CSUM,
    DONE,
    ERR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_HDR  = 2'd1,
    ERR_CSUM = 2'd2,
    ERR_TMO  = 2'd3
  } err_t;

  localparam int unsigned NUM_VEC       = 20;
  localparam int unsigned PAYLOAD_BYTES = 80;
  localparam int unsigned WORD_W        = $clog2(NUM_VEC);

  localparam int unsigned VEC_SP    = 0;
  localparam int unsigned VEC_RESET = 1;
  localparam int unsigned VEC_NMI   = 2;
  localparam int unsigned VEC_FAULT = 3;
  localparam int unsigned VEC_IRQ0  = 4;

endpackage

// File: rtl/vec_byte_assembler.sv
// Assembles the little-endian payload byte stream into 20 vector words and
// keeps the running payload checksum.
module vec_byte_assembler
  import vec_loader_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           load_en,
  input  logic [7:0]                     data,
  output logic [NUM_VEC-1:0][31:0]       vec,
  output logic [7:0]                     csum_acc,
  output logic                           last_byte
);

  logic [1:0]                byte_cnt;
  logic [WORD_W-1:0]         word_cnt;
  logic [NUM_VEC-1:0][3:0]   lane_we;

  always_comb begin
    lane_we = '0;
    if (load_en) begin
      lane_we[word_cnt][byte_cnt] = 1'b1;
    end
  end

  assign last_byte = (word_cnt == WORD_W'(NUM_VEC - 1)) && (byte_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      vec      <= '0;
      byte_cnt <= '0;
      word_cnt <= '0;
      csum_acc <= '0;
    end else if (load_en) begin
      csum_acc <= csum_acc + data;
      byte_cnt <= byte_cnt + 2'd1;
      if (byte_cnt == 2'd3) begin
        word_cnt <= word_cnt + WORD_W'(1);
      end
      for (int unsigned w = 0; w < NUM_VEC; w++) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (lane_we[w][b]) begin
            vec[w][8*b +: 8] <= data;
          end
        end
      end
    end
  end

endmodule

// File: rtl/vec_table_loader.sv
// Boot-time exception vector table loader: receives a checksummed byte frame,
// commits the 20-word table and releases the CPU reset only on a good frame.
module vec_table_loader
  import vec_loader_pkg::*;
#(
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        start,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        vec_valid,
  output logic        cpu_rst_hold,
  output logic        load_err,
  output logic [1:0]  err_code,
  output logic [31:0] sp_addr,
  output logic [31:0] reset_addr,
  output logic [31:0] nmi_addr,
  output logic [31:0] fault_addr,
  output logic [31:0] irq0_addr,
  output logic [31:0] irq1_addr,
  output logic [31:0] irq2_addr,
  output logic [31:0] irq3_addr,
  output logic [31:0] irq4_addr,
  output logic [31:0] irq5_addr,
  output logic [31:0] irq6_addr,
  output logic [31:0] irq7_addr,
  output logic [31:0] irq8_addr,
  output logic [31:0] irq9_addr,
  output logic [31:0] irq10_addr,
  output logic [31:0] irq11_addr,
  output logic [31:0] irq12_addr,
  output logic [31:0] irq13_addr,
  output logic [31:0] irq14_addr,
  output logic [31:0] irq15_addr
);

  localparam int unsigned     TMO_W   = $clog2(TIMEOUT_CYC);
  // Firing one count early makes ERR land TIMEOUT_CYC-1 cycles after the last byte.
  localparam logic [TMO_W-1:0] TMO_HIT = TMO_W'(TIMEOUT_CYC - 2);

  state_t                    state, next_state;
  err_t                      err_q, err_next;
  logic [TMO_W-1:0]          tmo_cnt;
  logic                      accept, in_frame, tmo_hit, enter_hdr, load_en, last_byte;
  logic [7:0]                csum_acc, csum_sum;
  logic [NUM_VEC-1:0][31:0]  vec_regs, vec_out;

  assign in_frame  = (state == HDR) || (state == LOAD) || (state == CSUM);
  assign s_ready   = in_frame;
  assign accept    = s_valid && s_ready;
  assign tmo_hit   = (tmo_cnt == TMO_HIT);
  assign csum_sum  = csum_acc + s_data;
  assign load_en   = accept && (state == LOAD);
  assign enter_hdr = (next_state == HDR) && (state != HDR);

  vec_byte_assembler u_asm (
    .clk       (hclk),
    .rst       (hreset),
    .clear     (enter_hdr),
    .load_en   (load_en),
    .data      (s_data),
    .vec       (vec_regs),
    .csum_acc  (csum_acc),
    .last_byte (last_byte)
  );

  always_comb begin
    next_state = state;
    err_next   = err_q;
    unique case (state)
      IDLE: begin
        if (start) next_state = HDR;
      end
      HDR: begin
        if (accept) begin
          if (s_data == HDR_BYTE) begin
            next_state = LOAD;
          end else begin
            next_state = ERR;
            err_next   = ERR_HDR;
          end
        end else if (tmo_hit) begin
          next_state = ERR;
          err_next   = ERR_TMO;
        end
      end
      LOAD: begin
        if (accept) begin
          if (last_byte) next_state = CSUM;
        end else if (tmo_hit) begin
          next_state = ERR;
          err_next   = ERR_TMO;
        end
      end
      CSUM: begin
        if (accept) begin
          if (csum_sum == 8'h00) begin
            next_state = DONE;
          end else begin
            next_state = ERR;
            err_next   = ERR_CSUM;
          end
        end else if (tmo_hit) begin
          next_state = ERR;
          err_next   = ERR_TMO;
        end
      end
      DONE, ERR: begin
        if (start) begin
          next_state = HDR;
          err_next   = ERR_NONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state        <= IDLE;
      err_q        <= ERR_NONE;
      vec_valid    <= 1'b0;
      cpu_rst_hold <= 1'b1;
      load_err     <= 1'b0;
    end else begin
      state        <= next_state;
      err_q        <= err_next;
      vec_valid    <= (next_state == DONE);
      cpu_rst_hold <= (next_state != DONE);
      load_err     <= (next_state == ERR);
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset || enter_hdr || accept || !in_frame) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign err_code = err_q;

  // Downstream must never observe a partially loaded table.
  always_comb begin
    vec_out = '0;
    for (int unsigned i = 0; i < NUM_VEC; i++) begin
      vec_out[i] = vec_regs[i] & {32{vec_valid}};
    end
  end

  assign sp_addr    = vec_out[VEC_SP];
  assign reset_addr = vec_out[VEC_RESET];
  assign nmi_addr   = vec_out[VEC_NMI];
  assign fault_addr = vec_out[VEC_FAULT];
  assign irq0_addr  = vec_out[VEC_IRQ0 + 0];
  assign irq1_addr  = vec_out[VEC_IRQ0 + 1];
  assign irq2_addr  = vec_out[VEC_IRQ0 + 2];
  assign irq3_addr  = vec_out[VEC_IRQ0 + 3];
  assign irq4_addr  = vec_out[VEC_IRQ0 + 4];
  assign irq5_addr  = vec_out[VEC_IRQ0 + 5];
  assign irq6_addr  = vec_out[VEC_IRQ0 + 6];
  assign irq7_addr  = vec_out[VEC_IRQ0 + 7];
  assign irq8_addr  = vec_out[VEC_IRQ0 + 8];
  assign irq9_addr  = vec_out[VEC_IRQ0 + 9];
  assign irq10_addr = vec_out[VEC_IRQ0 + 10];
  assign irq11_addr = vec_out[VEC_IRQ0 + 11];
  assign irq12_addr = vec_out[VEC_IRQ0 + 12];
  assign irq13_addr = vec_out[VEC_IRQ0 + 13];
  assign irq14_addr = vec_out[VEC_IRQ0 + 14];
  assign irq15_addr = vec_out[VEC_IRQ0 + 15];

endmodule

// File: tb/tb_vec_table_loader.sv
// Self-checking bench for vec_table_loader: frames are built from a word table
// and the expected outputs come from that table plus the frame rules.
module tb_vec_table_loader;

  localparam int unsigned TMO = 1024;

  logic        hclk = 1'b0;
  logic        hreset, start, s_valid;
  logic [7:0]  s_data;
  logic        s_ready, vec_valid, cpu_rst_hold, load_err;
  logic [1:0]  err_code;
  logic [31:0] sp_addr, reset_addr, nmi_addr, fault_addr;
  logic [31:0] irq0_addr, irq1_addr, irq2_addr, irq3_addr, irq4_addr, irq5_addr;
  logic [31:0] irq6_addr, irq7_addr, irq8_addr, irq9_addr, irq10_addr, irq11_addr;
  logic [31:0] irq12_addr, irq13_addr, irq14_addr, irq15_addr;
  logic [31:0] got [20];

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] tbl [20];
  logic [31:0] exp_tbl [20];
  bit          exp_valid;
  logic [7:0]  frm [82];

  vec_table_loader #(.HDR_BYTE(8'hA5), .TIMEOUT_CYC(TMO)) dut (
    .hclk(hclk), .hreset(hreset), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .vec_valid(vec_valid), .cpu_rst_hold(cpu_rst_hold),
    .load_err(load_err), .err_code(err_code),
    .sp_addr(sp_addr), .reset_addr(reset_addr), .nmi_addr(nmi_addr), .fault_addr(fault_addr),
    .irq0_addr(irq0_addr), .irq1_addr(irq1_addr), .irq2_addr(irq2_addr), .irq3_addr(irq3_addr),
    .irq4_addr(irq4_addr), .irq5_addr(irq5_addr), .irq6_addr(irq6_addr), .irq7_addr(irq7_addr),
    .irq8_addr(irq8_addr), .irq9_addr(irq9_addr), .irq10_addr(irq10_addr), .irq11_addr(irq11_addr),
    .irq12_addr(irq12_addr), .irq13_addr(irq13_addr), .irq14_addr(irq14_addr), .irq15_addr(irq15_addr)
  );

  assign got[0]  = sp_addr;    assign got[1]  = reset_addr;
  assign got[2]  = nmi_addr;   assign got[3]  = fault_addr;
  assign got[4]  = irq0_addr;  assign got[5]  = irq1_addr;
  assign got[6]  = irq2_addr;  assign got[7]  = irq3_addr;
  assign got[8]  = irq4_addr;  assign got[9]  = irq5_addr;
  assign got[10] = irq6_addr;  assign got[11] = irq7_addr;
  assign got[12] = irq8_addr;  assign got[13] = irq9_addr;
  assign got[14] = irq10_addr; assign got[15] = irq11_addr;
  assign got[16] = irq12_addr; assign got[17] = irq13_addr;
  assign got[18] = irq14_addr; assign got[19] = irq15_addr;

  always #5 hclk = ~hclk;

  task automatic cycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic open_frame();
    start = 1'b1;
    cycle();
    start = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    repeat (gap) cycle();
    s_valid = 1'b1;
    s_data  = b;
    cycle();
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  // Header, 80 little-endian payload bytes, then the byte that zeroes the sum.
  task automatic make_frame(input bit bad_csum);
    int unsigned sum;
    logic [31:0] w;
    sum = 0;
    frm[0] = 8'hA5;
    for (int i = 0; i < 20; i++) begin
      w = tbl[i];
      for (int b = 0; b < 4; b++) begin
        frm[1 + 4*i + b] = w[8*b +: 8];
        sum += int'(w[8*b +: 8]);
      end
    end
    frm[81] = 8'((256 - (sum % 256)) % 256 + (bad_csum ? 1 : 0));
  endtask

  task automatic random_table();
    for (int i = 0; i < 20; i++) tbl[i] = $urandom;
  endtask

  task automatic send_range(input int first, input int last, input int unsigned maxgap);
    for (int i = first; i <= last; i++) send_byte(frm[i], $urandom_range(0, maxgap));
  endtask

  task automatic commit_model();
    for (int i = 0; i < 20; i++) exp_tbl[i] = tbl[i];
    exp_valid = 1'b1;
  endtask

  task automatic test_reset();
    hreset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    exp_valid = 1'b0;
    cycle(); cycle();
    hreset = 1'b0;
    s_valid = 1'b1; s_data = 8'hA5;
    cycle(); cycle(); cycle();
    s_valid = 1'b0;
    checks++; if (vec_valid !== 1'b0) begin errors++; $display("FAIL reset_vec_valid got %b exp 0", vec_valid); end
    checks++; if (cpu_rst_hold !== 1'b1) begin errors++; $display("FAIL reset_hold got %b exp 1", cpu_rst_hold); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err got %b exp 0", load_err); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code got %0d exp 0", err_code); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b exp 0", s_ready); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (got[i] !== 32'h0) begin errors++; $display("FAIL reset_vec%0d got %h exp 0", i, got[i]); end
    end
  endtask

  task automatic test_nominal();
    for (int i = 0; i < 20; i++) tbl[i] = 32'h0;
    tbl[0] = 32'h2000_1000; tbl[1] = 32'h0000_0101; tbl[19] = 32'h0000_0F01;
    make_frame(1'b0);
    open_frame();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL nom_s_ready got %b exp 1", s_ready); end
    send_range(0, 80, 0);
    checks++; if (vec_valid !== 1'b0) begin errors++; $display("FAIL nom_pre_valid got %b exp 0", vec_valid); end
    checks++; if (sp_addr !== 32'h0) begin errors++; $display("FAIL nom_pre_sp got %h exp 0", sp_addr); end
    send_byte(frm[81], 0);
    commit_model();
    checks++; if (vec_valid !== 1'b1) begin errors++; $display("FAIL nom_vec_valid got %b exp 1", vec_valid); end
    checks++; if (cpu_rst_hold !== 1'b0) begin errors++; $display("FAIL nom_hold got %b exp 0", cpu_rst_hold); end
    checks++; if (sp_addr !== 32'h2000_1000) begin errors++; $display("FAIL nom_sp got %h exp 20001000", sp_addr); end
    checks++; if (irq15_addr !== 32'h0000_0F01) begin errors++; $display("FAIL nom_irq15 got %h exp 00000f01", irq15_addr); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (got[i] !== exp_tbl[i]) begin errors++; $display("FAIL nom_vec%0d got %h exp %h", i, got[i], exp_tbl[i]); end
    end
    // Bytes offered outside a frame must not be consumed.
    for (int k = 0; k < 4; k++) send_byte(8'($urandom), 0);
    checks++; if (vec_valid !== 1'b1) begin errors++; $display("FAIL idle_bytes_valid got %b exp 1", vec_valid); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (got[i] !== exp_tbl[i]) begin errors++; $display("FAIL idle_bytes_vec%0d got %h exp %h", i, got[i], exp_tbl[i]); end
    end
  endtask

  task automatic test_bad_header();
    open_frame();
    checks++; if (vec_valid !== 1'b0) begin errors++; $display("FAIL hdr_drop_valid got %b exp 0", vec_valid); end
    send_byte(8'h5A, 0);
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL hdr_load_err got %b exp 1", load_err); end
    checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL hdr_err_code got %0d exp 1", err_code); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL hdr_s_ready got %b exp 0", s_ready); end
    checks++; if (cpu_rst_hold !== 1'b1) begin errors++; $display("FAIL hdr_hold got %b exp 1", cpu_rst_hold); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (got[i] !== 32'h0) begin errors++; $display("FAIL hdr_vec%0d got %h exp 0", i, got[i]); end
    end
  endtask

  task automatic test_bad_checksum();
    for (int i = 0; i < 20; i++) tbl[i] = 32'h0;
    tbl[0] = 32'h2000_1000; tbl[1] = 32'h0000_0101; tbl[19] = 32'h0000_0F01;
    make_frame(1'b1);
    open_frame();
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL csum_clear_err got %0d exp 0", err_code); end
    send_range(0, 81, 2);
    checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL csum_err_code got %0d exp 2", err_code); end
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL csum_load_err got %b exp 1", load_err); end
    checks++; if (vec_valid !== 1'b0) begin errors++; $display("FAIL csum_vec_valid got %b exp 0", vec_valid); end
    checks++; if (sp_addr !== 32'h0) begin errors++; $display("FAIL csum_sp got %h exp 0", sp_addr); end
  endtask

  task automatic test_timeout();
    int unsigned n_err;
    random_table();
    make_frame(1'b0);
    open_frame();
    send_range(0, 10, 3);
    n_err = 0;
    for (int unsigned n = 1; n <= TMO + 4; n++) begin
      cycle();
      if (err_code == 2'd3) begin
        n_err = n;
        break;
      end
    end
    checks++; if (n_err !== TMO - 1) begin errors++; $display("FAIL tmo_latency got %0d exp %0d", n_err, TMO - 1); end
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL tmo_load_err got %b exp 1", load_err); end
    checks++; if (cpu_rst_hold !== 1'b1) begin errors++; $display("FAIL tmo_hold got %b exp 1", cpu_rst_hold); end
  endtask

  task automatic test_backpressure();
    random_table();
    make_frame(1'b0);
    open_frame();
    for (int i = 0; i <= 81; i++) begin
      if (i == 50) start = 1'b1;
      // Gap of TIMEOUT-2 idle cycles: byte arrives on the terminal count and must win.
      send_byte(frm[i], (i == 37) ? TMO - 2 : $urandom_range(0, 12));
      start = 1'b0;
      if (i == 37) begin
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL bp_edge_gap_err got %b exp 0", load_err); end
      end
    end
    commit_model();
    checks++; if (vec_valid !== 1'b1) begin errors++; $display("FAIL bp_vec_valid got %b exp 1", vec_valid); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (got[i] !== exp_tbl[i]) begin errors++; $display("FAIL bp_vec%0d got %h exp %h", i, got[i], exp_tbl[i]); end
    end
  endtask

  task automatic test_hreset_abort();
    random_table();
    make_frame(1'b0);
    open_frame();
    send_range(0, 40, 2);
    hreset = 1'b1;
    cycle();
    hreset = 1'b0;
    exp_valid = 1'b0;
    checks++; if (vec_valid !== 1'b0) begin errors++; $display("FAIL abort_vec_valid got %b exp 0", vec_valid); end
    checks++; if (cpu_rst_hold !== 1'b1) begin errors++; $display("FAIL abort_hold got %b exp 1", cpu_rst_hold); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL abort_load_err got %b exp 0", load_err); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL abort_err_code got %0d exp 0", err_code); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL abort_s_ready got %b exp 0", s_ready); end
    random_table();
    make_frame(1'b0);
    open_frame();
    send_range(0, 81, 3);
    commit_model();
    checks++; if (vec_valid !== 1'b1) begin errors++; $display("FAIL abort_reload_valid got %b exp 1", vec_valid); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (got[i] !== exp_tbl[i]) begin errors++; $display("FAIL abort_vec%0d got %h exp %h", i, got[i], exp_tbl[i]); end
    end
  endtask

  task automatic test_reload();
    tbl[2] = 32'hDEAD_BEEF;
    make_frame(1'b0);
    open_frame();
    checks++; if (vec_valid !== 1'b0) begin errors++; $display("FAIL reload_drop_valid got %b exp 0", vec_valid); end
    checks++; if (cpu_rst_hold !== 1'b1) begin errors++; $display("FAIL reload_hold got %b exp 1", cpu_rst_hold); end
    send_range(0, 40, 1);
    for (int i = 0; i < 20; i++) begin
      checks++; if (got[i] !== 32'h0) begin errors++; $display("FAIL reload_mid_vec%0d got %h exp 0", i, got[i]); end
    end
    send_range(41, 81, 1);
    commit_model();
    checks++; if (nmi_addr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reload_nmi got %h exp deadbeef", nmi_addr); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (got[i] !== exp_tbl[i]) begin errors++; $display("FAIL reload_vec%0d got %h exp %h", i, got[i], exp_tbl[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_header();
    test_bad_checksum();
    test_timeout();
    test_backpressure();
    test_hreset_abort();
    test_reload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
